// File: rtl/data_mem_ctrl.sv
// Multi-cycle 256x32 data memory: byte-enabled stores, sign/zero-extended loads, done after WAIT_CYCLES+1 cycles.
// Backpressure: stall is raised combinationally for a request in IDLE and held through BUSY.
module data_mem_ctrl #(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH_LOG2  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ramAddr,
  input  logic [3:0]  ramSel,
  input  logic [31:0] wdata,
  input  logic [2:0]  loadop,
  output logic [31:0] rdata,
  output logic        done,
  output logic        stall,
  output logic        fault
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [2:0] OP_LB  = 3'd1;
  localparam logic [2:0] OP_LBU = 3'd2;
  localparam logic [2:0] OP_LH  = 3'd3;
  localparam logic [2:0] OP_LHU = 3'd4;
  localparam logic [2:0] OP_LW  = 3'd5;

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_cnt;
  logic [DEPTH_LOG2+1:0] r_addr;
  logic [3:0]            r_sel;
  logic [31:0]           r_wdata;
  logic [2:0]            r_loadop;
  logic                  r_fault;
  logic [31:0]           r_mem [0:(1<<DEPTH_LOG2)-1];

  logic                  w_req;
  logic                  w_last;
  logic                  w_ld_vld;
  logic                  w_store;
  logic                  w_misalign;
  logic [31:0]           w_word;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [31:0]           w_load_val;
  logic                  w_unused_addr;

  // Address bits above the memory size are deliberately dropped (wrap-around).
  assign w_unused_addr = ^ramAddr[31:DEPTH_LOG2+2];

  assign w_req      = (ramSel != 4'b0000) || (loadop >= OP_LB && loadop <= OP_LW);
  assign w_last     = (r_state == BUSY) && (r_cnt == 4'd1);
  assign w_ld_vld   = (r_loadop >= OP_LB) && (r_loadop <= OP_LW);
  assign w_store    = (r_sel != 4'b0000);
  assign w_misalign = (((r_loadop == OP_LH) || (r_loadop == OP_LHU)) && r_addr[0]) ||
                      ((r_loadop == OP_LW) && (r_addr[1:0] != 2'b00));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    stall  = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          stall  = 1'b1;
          w_next = BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (r_cnt <= 4'd1) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= 4'd0;
      r_addr   <= '0;
      r_sel    <= 4'b0000;
      r_wdata  <= 32'd0;
      r_loadop <= 3'd0;
    end else if (r_state == IDLE && w_req) begin
      r_cnt    <= 4'(WAIT_CYCLES);
      r_addr   <= ramAddr[DEPTH_LOG2+1:0];
      r_sel    <= ramSel;
      r_wdata  <= wdata;
      r_loadop <= loadop;
    end else if (r_state == BUSY) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Single write on the final BUSY edge; an aborting reset leaves memory untouched.
  always_ff @(posedge clk) begin
    if (!rst && w_last && w_store) begin
      for (int b = 0; b < 4; b++) begin
        if (r_sel[b]) r_mem[r_addr[DEPTH_LOG2+1:2]][8*b +: 8] <= r_wdata[8*b +: 8];
      end
    end
  end

  assign w_word = r_mem[r_addr[DEPTH_LOG2+1:2]];
  assign w_half = r_addr[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_byte = w_word[7:0];
    case (r_addr[1:0])
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      2'd3:    w_byte = w_word[31:24];
      default: w_byte = w_word[7:0];
    endcase
  end

  always_comb begin
    w_load_val = 32'd0;
    case (r_loadop)
      OP_LB:   w_load_val = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  w_load_val = {24'd0, w_byte};
      OP_LH:   w_load_val = {{16{w_half[15]}}, w_half};
      OP_LHU:  w_load_val = {16'd0, w_half};
      OP_LW:   w_load_val = w_word;
      default: w_load_val = 32'd0;
    endcase
  end

  // A store wins over a simultaneous load, so rdata only moves on a pure load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata   <= 32'd0;
      r_fault <= 1'b0;
    end else begin
      r_fault <= w_last && w_ld_vld && (w_store || w_misalign);
      if (w_last && w_ld_vld && !w_store) rdata <= w_load_val;
    end
  end

  assign fault = r_fault;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed table-driven bench for data_mem_ctrl plus reset-abort and idle sequences.
module tb_data_mem_ctrl;

  localparam int WAIT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ramAddr;
  logic [3:0]  ramSel;
  logic [31:0] wdata;
  logic [2:0]  loadop;
  logic [31:0] rdata;
  logic        done;
  logic        stall;
  logic        fault;

  int n_chk  = 0;
  int n_fail = 0;

  data_mem_ctrl #(.WAIT_CYCLES(WAIT), .DEPTH_LOG2(8)) dut (
    .clk(clk), .rst(rst), .ramAddr(ramAddr), .ramSel(ramSel), .wdata(wdata),
    .loadop(loadop), .rdata(rdata), .done(done), .stall(stall), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wd;
    logic [2:0]  op;
    logic [31:0] exp_rd;
    logic        exp_flt;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issues one request and follows it to done; leaves the bench at negedge+1 of the cycle after DONE.
  task automatic access(input string name, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input logic [2:0] op,
                        input logic [31:0] exp_rd, input logic exp_flt);
    int stall_cnt;
    int done_cyc;
    logic [31:0] rd;
    logic flt;
    @(negedge clk);
    ramAddr = a; ramSel = s; wdata = d; loadop = op;
    #1;
    stall_cnt = 0;
    done_cyc  = -1;
    rd  = 32'hx;
    flt = 1'bx;
    for (int c = 0; c < 40 && done_cyc < 0; c++) begin
      if (c > 0) begin
        @(negedge clk);
        #1;
      end
      if (stall) stall_cnt++;
      if (done) begin
        done_cyc = c;
        rd  = rdata;
        flt = fault;
        ramSel = 4'b0000; loadop = 3'd0;
      end
    end
    ramSel = 4'b0000; loadop = 3'd0;
    chk({name, " done_cycle"}, 32'(done_cyc), 32'(WAIT + 1));
    chk({name, " stall_cycles"}, 32'(stall_cnt), 32'(WAIT + 1));
    chk({name, " rdata"}, rd, exp_rd);
    chk({name, " fault"}, {31'd0, flt}, {31'd0, exp_flt});
    @(negedge clk);
    #1;
    chk({name, " pulse_end"}, {30'd0, done, fault}, 32'd0);
  endtask

  initial begin
    logic [31:0] exp_rd;

    vecs[0]  = '{32'h10,  4'hF, 32'hDEADBEEF, 3'd0, 32'h00000000, 1'b0};
    vecs[1]  = '{32'h10,  4'h0, 32'h0,        3'd5, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{32'h20,  4'hF, 32'h0,        3'd0, 32'hDEADBEEF, 1'b0};
    vecs[3]  = '{32'h22,  4'h4, 32'h80808080, 3'd0, 32'hDEADBEEF, 1'b0};
    vecs[4]  = '{32'h22,  4'h0, 32'h0,        3'd1, 32'hFFFFFF80, 1'b0};
    vecs[5]  = '{32'h22,  4'h0, 32'h0,        3'd2, 32'h00000080, 1'b0};
    vecs[6]  = '{32'h20,  4'h0, 32'h0,        3'd1, 32'h00000000, 1'b0};
    vecs[7]  = '{32'h30,  4'hF, 32'h80017FFF, 3'd0, 32'h00000000, 1'b0};
    vecs[8]  = '{32'h32,  4'h0, 32'h0,        3'd3, 32'hFFFF8001, 1'b0};
    vecs[9]  = '{32'h30,  4'h0, 32'h0,        3'd4, 32'h00007FFF, 1'b0};
    vecs[10] = '{32'h31,  4'h0, 32'h0,        3'd3, 32'h00007FFF, 1'b1};
    vecs[11] = '{32'h33,  4'h0, 32'h0,        3'd5, 32'h80017FFF, 1'b1};
    vecs[12] = '{32'h400, 4'hF, 32'h12345678, 3'd5, 32'h80017FFF, 1'b1};
    vecs[13] = '{32'h0,   4'h0, 32'h0,        3'd5, 32'h12345678, 1'b0};
    vecs[14] = '{32'h10,  4'h8, 32'hAB000000, 3'd6, 32'h12345678, 1'b0};
    vecs[15] = '{32'h10,  4'h0, 32'h0,        3'd5, 32'hABADBEEF, 1'b0};
    vecs[16] = '{32'h33,  4'h0, 32'h0,        3'd1, 32'hFFFFFF80, 1'b0};
    vecs[17] = '{32'h31,  4'h0, 32'h0,        3'd2, 32'h0000007F, 1'b0};
    vecs[18] = '{32'h40,  4'hF, 32'h11111111, 3'd0, 32'h0000007F, 1'b0};

    rst = 1'b1; ramAddr = 32'd0; ramSel = 4'b0000; wdata = 32'd0; loadop = 3'd0;
    #1;
    chk("reset_ctrl", {29'd0, stall, done, fault}, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // First vector lands in the first cycle after reset release.
    for (int i = 0; i < 19; i++)
      access($sformatf("vec%0d", i), vecs[i].addr, vecs[i].sel, vecs[i].wd,
             vecs[i].op, vecs[i].exp_rd, vecs[i].exp_flt);

    // Reset while the store to 0x40 is in BUSY must abort it.
    @(negedge clk);
    ramAddr = 32'h40; ramSel = 4'hF; wdata = 32'hAAAAAAAA; loadop = 3'd0;
    #1 chk("abort_req_stall", {31'd0, stall}, 32'd1);
    @(negedge clk);
    #1 chk("abort_busy_stall", {31'd0, stall}, 32'd1);
    rst = 1'b1; ramSel = 4'b0000;
    #1;
    chk("abort_ctrl", {29'd0, stall, done, fault}, 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1 chk($sformatf("abort_quiet%0d", c), {29'd0, stall, done, fault}, 32'd0);
    end
    access("abort_readback", 32'h40, 4'h0, 32'h0, 3'd5, 32'h11111111, 1'b0);
    exp_rd = 32'h11111111;

    // Reserved loadop with no store is not a request.
    ramSel = 4'b0000; loadop = 3'd6; ramAddr = 32'h40;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("idle%0d_ctrl", c), {29'd0, stall, done, fault}, 32'd0);
      chk($sformatf("idle%0d_rdata", c), rdata, exp_rd);
    end
    loadop = 3'd0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded 50000 time units");
    $fatal(1);
  end

endmodule
